// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl
//   Fetch controller between the program counter and decode. It issues one
//   instruction-memory read per instruction at the current PC, steps the PC
//   when the word returns, parks the word in an instruction register and
//   hands it to decode with a valid/ready handshake. Control-flow redirects
//   reload the PC and flush any read that is still in flight.
//
//   Optional feature macro: FETCH_TIMEOUT_EN
//     When defined, a wait counter watches outstanding reads. A read that
//     gets no ack within TIMEOUT_CYC cycles raises the sticky fetch_err and
//     parks the controller in ERR until reset. When undefined, reads wait
//     indefinitely and fetch_err is tied low.
module instr_fetch_ctrl #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
`ifdef FETCH_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYC = 255
`endif
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              fetch_en,
   input  logic [ADDR_W-1:0] pc,
   output logic              pc_inc,
   output logic              pc_load,
   output logic [ADDR_W-1:0] pc_din,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [DATA_W-1:0] imem_rdata,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_addr,
   output logic              ir_valid,
   input  logic              ir_ready,
   output logic [DATA_W-1:0] ir_data,
   output logic [ADDR_W-1:0] ir_pc,
   output logic              fetch_err
);

`ifdef FETCH_TIMEOUT_EN
   typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_HOLD, ST_FLUSH, ST_ERR} state_t;
`else
   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_HOLD, ST_FLUSH} state_t;
`endif

   state_t              state_reg;
   state_t              state_next;
   logic [DATA_W-1:0]   ir_data_reg;
   logic [ADDR_W-1:0]   ir_pc_reg;

   // A redirect that the current state actually honours (ERR ignores them).
   logic                redirect_eff;
   // A read completes into the IR: ack in WAIT with no competing redirect.
   logic                fetch_done;
   // The outstanding read has waited too long (always 0 without the timer).
   logic                timeout_hit;

   assign fetch_done = (state_reg == ST_WAIT) && imem_ack && !redirect_eff;

`ifdef FETCH_TIMEOUT_EN
   localparam int TIMER_W = $clog2(TIMEOUT_CYC + 1);

   logic [TIMER_W-1:0] timer_reg;
   logic               fetch_err_reg;
   logic               read_pending;

   assign read_pending = (state_reg == ST_WAIT) || (state_reg == ST_FLUSH);
   assign timeout_hit  = read_pending && !imem_ack &&
                         (timer_reg == TIMER_W'(TIMEOUT_CYC - 1));
   assign redirect_eff = redirect && (state_reg != ST_ERR);
   assign fetch_err    = fetch_err_reg;

   // Count cycles spent waiting on memory; any ack or leaving the wait clears it.
   always_ff @(posedge clk) begin
      if (reset) begin
         timer_reg <= '0;
      end else if (read_pending && !imem_ack) begin
         timer_reg <= timer_reg + TIMER_W'(1);
      end else begin
         timer_reg <= '0;
      end
   end

   // Sticky error flag: only reset clears it.
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_err_reg <= 1'b0;
      end else if (timeout_hit) begin
         fetch_err_reg <= 1'b1;
      end
   end
`else
   assign timeout_hit  = 1'b0;
   assign redirect_eff = redirect;
   assign fetch_err    = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic: redirects take priority over normal progress,
   // and a timeout takes priority over everything while a read is pending.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: begin
            if (fetch_en && !redirect_eff) begin
               state_next = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (timeout_hit) begin
`ifdef FETCH_TIMEOUT_EN
               state_next = ST_ERR;
`endif
            end else if (redirect_eff) begin
               // With the ack in the same cycle the response is simply
               // dropped; otherwise it is still owed and must be swallowed.
               state_next = imem_ack ? ST_IDLE : ST_FLUSH;
            end else if (imem_ack) begin
               state_next = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (redirect_eff) begin
               state_next = ST_IDLE;
            end else if (ir_ready) begin
               state_next = fetch_en ? ST_WAIT : ST_IDLE;
            end
         end
         ST_FLUSH: begin
            if (timeout_hit) begin
`ifdef FETCH_TIMEOUT_EN
               state_next = ST_ERR;
`endif
            end else if (imem_ack) begin
               state_next = ST_IDLE;
            end
         end
`ifdef FETCH_TIMEOUT_EN
         ST_ERR: begin
            state_next = ST_ERR;
         end
`endif
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Output decode: PC control, memory request and IR valid.
   always_comb begin
      pc_inc    = fetch_done;
      pc_load   = redirect_eff;
      pc_din    = redirect_eff ? redirect_addr : '0;
      imem_req  = (state_reg == ST_WAIT) || (state_reg == ST_FLUSH);
      imem_addr = (state_reg == ST_WAIT) ? pc : '0;
      ir_valid  = (state_reg == ST_HOLD);
   end

   // Instruction register: captured only when a read completes into HOLD,
   // so it stays stable for the whole decode stall.
   always_ff @(posedge clk) begin
      if (reset) begin
         ir_data_reg <= '0;
         ir_pc_reg   <= '0;
      end else if (fetch_done) begin
         ir_data_reg <= imem_rdata;
         ir_pc_reg   <= pc;
      end
   end

   assign ir_data = ir_data_reg;
   assign ir_pc   = ir_pc_reg;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// tb_instr_fetch_ctrl
//   Drives instr_fetch_ctrl with a PC counter and a latency-configurable
//   memory model. Expected instruction addresses live in a scoreboard queue:
//   reset and each redirect replace its contents, and the monitor pops one
//   entry per decode handshake and pushes the sequential successor.
module tb_instr_fetch_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        fetch_en;
   logic [31:0] pc;
   logic        pc_inc;
   logic        pc_load;
   logic [31:0] pc_din;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        redirect;
   logic [31:0] redirect_addr;
   logic        ir_valid;
   logic        ir_ready;
   logic [31:0] ir_data;
   logic [31:0] ir_pc;
   logic        fetch_err;

   always #5 clk = ~clk;

`ifdef FETCH_TIMEOUT_EN
   instr_fetch_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(8)) dut (
`else
   instr_fetch_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
`endif
      .clk(clk), .reset(reset), .fetch_en(fetch_en), .pc(pc),
      .pc_inc(pc_inc), .pc_load(pc_load), .pc_din(pc_din),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
      .imem_rdata(imem_rdata), .redirect(redirect), .redirect_addr(redirect_addr),
      .ir_valid(ir_valid), .ir_ready(ir_ready), .ir_data(ir_data), .ir_pc(ir_pc),
      .fetch_err(fetch_err)
   );

   int vectors = 0;
   int miscompares = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h5A5A_1234;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Scoreboard: head is the address of the next instruction decode should see.
   logic [31:0] exp_q[$];

   task automatic sb_restart(input logic [31:0] a);
      exp_q.delete();
      exp_q.push_back(a);
   endtask

   // PC counter environment: reset value 0x10, load beats increment.
   always @(posedge clk) begin
      if (reset) pc <= 32'h10;
      else if (pc_load) pc <= pc_din;
      else if (pc_inc) pc <= pc + 32'd1;
   end

   // Memory responder. lat_mode: 0 zero-wait, 1 three waits, 2 random 0..4, 3 never.
   int lat_mode = 0;
   initial begin : responder
      bit busy;
      int wcnt;
      busy = 0;
      wcnt = 0;
      imem_ack = 1'b0;
      imem_rdata = '0;
      forever begin
         @(negedge clk);
         imem_ack = 1'b0;
         if (reset || !imem_req) begin
            busy = 0;
         end else begin
            if (!busy) begin
               busy = 1;
               case (lat_mode)
                  0: wcnt = 0;
                  1: wcnt = 3;
                  2: wcnt = int'($urandom_range(0, 4));
                  default: wcnt = 1000000;
               endcase
            end
            if (wcnt == 0) begin
               imem_ack = 1'b1;
               imem_rdata = mem_word(imem_addr);
               busy = 0;
            end else begin
               wcnt--;
            end
         end
      end
   end

   // Monitor: samples mid-cycle, checks handshakes against the scoreboard
   // and cycle-to-cycle invariants.
   int          cyc = 0;
   int          xfer_cnt = 0;
   int          inc_cnt = 0;
   int          xfer_cyc_q[$];
   logic [31:0] xfer_pc_q[$];
   initial begin : monitor
      bit          p_hold, p_inc, xfer;
      logic [31:0] p_data, p_pc, p_addr, e;
      p_hold = 0; p_inc = 0; p_data = '0; p_pc = '0; p_addr = '0;
      forever begin
         @(negedge clk);
         #2;
         cyc++;
         if (reset) begin
            p_hold = 0;
            p_inc  = 0;
         end else begin
            chk("pc_load", pc_load, redirect);
            if (redirect) begin
               chk("pc_din", pc_din, redirect_addr);
               chk("no_inc_on_redirect", pc_inc, 0);
            end
            chk("req_while_valid", imem_req & ir_valid, 0);
`ifndef FETCH_TIMEOUT_EN
            chk("fetch_err", fetch_err, 0);
`endif
            if (pc_inc) chk("inc_needs_ack", imem_ack & imem_req, 1);
            if (p_hold) begin
               chk("hold_valid", ir_valid, 1);
               chk("hold_data", ir_data, p_data);
               chk("hold_pc", ir_pc, p_pc);
            end
            if (p_inc) begin
               chk("capture_valid", ir_valid, 1);
               chk("capture_pc", ir_pc, p_addr);
               chk("capture_data", ir_data, mem_word(p_addr));
            end
            xfer = ir_valid && ir_ready && !redirect;
            if (xfer) begin
               if (exp_q.size() == 0) begin
                  vectors++;
                  miscompares++;
                  $display("FAIL xfer_unexpected: got pc %h expected none", ir_pc);
               end else begin
                  e = exp_q.pop_front();
                  chk("xfer_pc", ir_pc, e);
                  chk("xfer_data", ir_data, mem_word(e));
                  exp_q.push_back(e + 32'd1);
               end
               xfer_cnt++;
               xfer_cyc_q.push_back(cyc);
               xfer_pc_q.push_back(ir_pc);
            end
            if (pc_inc) inc_cnt++;
            p_hold = ir_valid && !xfer && !redirect;
            p_inc  = pc_inc;
            p_data = ir_data;
            p_pc   = ir_pc;
            p_addr = imem_addr;
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; fetch_en = 1'b0; redirect = 1'b0; ir_ready = 1'b0;
      sb_restart(32'h10);
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic issue_redirect(input logic [31:0] a);
      redirect = 1'b1;
      redirect_addr = a;
      sb_restart(a);
   endtask

   // Stimulus.
   initial begin : stimulus
      int  base_inc, base_x, req_cnt, val_cnt;
      bit  found;
      reset = 1'b1; fetch_en = 1'b0; redirect = 1'b0; redirect_addr = '0; ir_ready = 1'b0;
      sb_restart(32'h10);
      repeat (2) @(negedge clk);
      reset = 1'b0;

      // Reset state: every output 0, no request without fetch_en.
      #1;
      chk("rst_pc_inc", pc_inc, 0);     chk("rst_pc_load", pc_load, 0);
      chk("rst_pc_din", pc_din, 0);     chk("rst_imem_req", imem_req, 0);
      chk("rst_imem_addr", imem_addr, 0); chk("rst_ir_valid", ir_valid, 0);
      chk("rst_ir_data", ir_data, 0);   chk("rst_ir_pc", ir_pc, 0);
      chk("rst_fetch_err", fetch_err, 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         chk("idle_no_req", imem_req, 0);
      end

      // Zero-wait stream: three fetches from 0x10, one every second cycle.
      @(negedge clk);
      xfer_cyc_q.delete(); xfer_pc_q.delete();
      base_inc = inc_cnt;
      lat_mode = 0; fetch_en = 1'b1; ir_ready = 1'b1;
      repeat (6) @(negedge clk);
      fetch_en = 1'b0;
      repeat (4) @(negedge clk);
      chk("zw_xfers", xfer_pc_q.size(), 3);
      if (xfer_pc_q.size() >= 3) begin
         for (int i = 0; i < 3; i++) chk("zw_ir_pc", xfer_pc_q[i], 32'h10 + i);
         chk("zw_spacing1", xfer_cyc_q[1] - xfer_cyc_q[0], 2);
         chk("zw_spacing2", xfer_cyc_q[2] - xfer_cyc_q[1], 2);
      end
      chk("zw_inc_count", inc_cnt - base_inc, xfer_pc_q.size());

      // Three wait states, decode stalls four cycles.
      lat_mode = 1; ir_ready = 1'b0;
      req_cnt = 0; val_cnt = 0; base_x = xfer_cnt;
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         fetch_en = (i == 0);
         ir_ready = (i >= 9);
         #1;
         if (imem_req) req_cnt++;
         if (ir_valid) val_cnt++;
      end
      chk("ws_req_cycles", req_cnt, 4);
      chk("ws_valid_cycles", val_cnt, 5);
      chk("ws_xfers", xfer_cnt - base_x, 1);

      // Redirect in WAIT one cycle before the ack.
      lat_mode = 1; ir_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         fetch_en = 1'b1;
         if (i == 3) begin
            issue_redirect(32'h200);
            #1;
            chk("rw_pc_load", pc_load, 1);
            chk("rw_req_held", imem_req, 1);
         end
      end
      @(negedge clk);
      redirect = 1'b0;
      found = 0;
      for (int i = 0; i < 10 && !found; i++) begin
         #1;
         if (!imem_req) found = 1;
         else @(negedge clk);
      end
      chk("rw_flush_done", found, 1);
      found = 0;
      for (int i = 0; i < 10 && !found; i++) begin
         @(negedge clk); #1;
         if (imem_req) found = 1;
      end
      chk("rw_refetch_seen", found, 1);
      chk("rw_refetch_addr", imem_addr, 32'h200);

      // Redirect in HOLD with a simultaneous ir_ready.
      lat_mode = 0; ir_ready = 1'b0; fetch_en = 1'b1;
      found = 0;
      for (int i = 0; i < 10 && !found; i++) begin
         @(negedge clk); #1;
         if (ir_valid) found = 1;
      end
      chk("rh_hold_seen", found, 1);
      ir_ready = 1'b1;
      issue_redirect(32'h300);
      #1;
      chk("rh_no_inc", pc_inc, 0);
      @(negedge clk);
      redirect = 1'b0;
      #1;
      chk("rh_valid_dropped", ir_valid, 0);
      base_x = xfer_cnt;
      found = 0;
      for (int i = 0; i < 10 && !found; i++) begin
         @(negedge clk); #3;
         if (xfer_cnt > base_x) found = 1;
      end
      chk("rh_next_xfer", found, 1);
      if (found) chk("rh_next_ir_pc", xfer_pc_q[xfer_pc_q.size() - 1], 32'h300);

      // Randomized traffic with random latency, redirects (some near wrap)
      // and a reset in the middle.
      lat_mode = 2; base_x = xfer_cnt;
      for (int i = 0; i < 1500; i++) begin
         if (i == 700) begin
            do_reset();
         end else begin
            @(negedge clk);
         end
         fetch_en = ($urandom_range(0, 9) < 8);
         ir_ready = ($urandom_range(0, 9) < 6);
         redirect = 1'b0;
         if ($urandom_range(0, 19) == 0) begin
            if ($urandom_range(0, 3) == 0) issue_redirect(32'hFFFF_FFFE);
            else issue_redirect($urandom);
         end
      end
      @(negedge clk);
      redirect = 1'b0; fetch_en = 1'b0; ir_ready = 1'b1;
      repeat (10) @(negedge clk);
      chk("rand_progress", (xfer_cnt - base_x) > 50, 1);

`ifdef FETCH_TIMEOUT_EN
      // Withheld ack: error after 8 waiting cycles, sticky until reset.
      do_reset();
      lat_mode = 3; req_cnt = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         fetch_en = (i == 0);
         #1;
         if (imem_req) req_cnt++;
      end
      chk("to_req_cycles", req_cnt, 8);
      chk("to_fetch_err", fetch_err, 1);
      chk("to_req_low", imem_req, 0);
      chk("to_valid_low", ir_valid, 0);
      do_reset();
      #1;
      chk("to_err_cleared", fetch_err, 0);
      lat_mode = 0;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
